// File: rtl/trace_checker.sv
// Golden-trace comparator: checks every committed register write against a FIFO
// of expected records loaded over a valid/ready handshake.
module trace_checker #(
  parameter int          DEPTH  = 8,
  parameter logic [31:0] END_PC = 32'h1c000100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] debug_wb_pc,
  input  logic [3:0]  debug_wb_rf_we,
  input  logic [4:0]  debug_wb_rf_wnum,
  input  logic [31:0] debug_wb_rf_wdata,
  input  logic        gold_valid,
  output logic        gold_ready,
  input  logic [31:0] gold_pc,
  input  logic [4:0]  gold_wnum,
  input  logic [31:0] gold_wdata,
  output logic        pass,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [31:0] err_pc,
  output logic [31:0] err_exp_wdata,
  output logic [31:0] err_got_wdata,
  output logic [31:0] retire_cnt
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t state, state_nx;

  logic [31:0] mem_pc    [DEPTH];
  logic [4:0]  mem_wnum  [DEPTH];
  logic [31:0] mem_wdata [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic        running, commit, check, empty, push, pop;
  logic [31:0] head_pc, head_wdata, byte_mask;
  logic [4:0]  head_wnum;
  logic        data_bad;
  logic [2:0]  code_nx;

  assign running    = (state == S_RUN);
  assign commit     = (debug_wb_rf_we != 4'b0000) && (debug_wb_rf_wnum != 5'd0);
  assign check      = commit && running;
  assign empty      = (count == '0);
  assign gold_ready = !reset && running && (count < FULL);
  assign push       = gold_valid && gold_ready;
  assign pop        = check && !empty;

  assign head_pc    = mem_pc[rd_ptr];
  assign head_wnum  = mem_wnum[rd_ptr];
  assign head_wdata = mem_wdata[rd_ptr];

  // Only bytes the CPU actually wrote take part in the data comparison.
  assign byte_mask = {{8{debug_wb_rf_we[3]}}, {8{debug_wb_rf_we[2]}},
                      {8{debug_wb_rf_we[1]}}, {8{debug_wb_rf_we[0]}}};
  assign data_bad  = ((debug_wb_rf_wdata ^ head_wdata) & byte_mask) != 32'd0;

  always_comb begin
    code_nx = 3'd0;
    if (check) begin
      if (empty)                             code_nx = 3'd4;
      else if (debug_wb_pc != head_pc)       code_nx = 3'd1;
      else if (debug_wb_rf_wnum != head_wnum) code_nx = 3'd2;
      else if (data_bad)                     code_nx = 3'd3;
    end
  end

  // An error on the END_PC cycle takes precedence over passing.
  always_comb begin
    state_nx = state;
    if (running) begin
      if (code_nx != 3'd0)           state_nx = S_FAIL;
      else if (debug_wb_pc == END_PC) state_nx = S_PASS;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_RUN;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      retire_cnt    <= 32'd0;
      err_code      <= 3'd0;
      err_pc        <= 32'd0;
      err_exp_wdata <= 32'd0;
      err_got_wdata <= 32'd0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      if (check) retire_cnt <= retire_cnt + 32'd1;
      if (code_nx != 3'd0) begin
        err_code      <= code_nx;
        err_pc        <= debug_wb_pc;
        err_exp_wdata <= empty ? 32'd0 : head_wdata;
        err_got_wdata <= debug_wb_rf_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= gold_pc;
      mem_wnum[wr_ptr]  <= gold_wnum;
      mem_wdata[wr_ptr] <= gold_wdata;
    end
  end

  assign pass = (state == S_PASS);
  assign err  = (state == S_FAIL);

endmodule

// File: tb/tb_trace_checker.sv
// Bench for trace_checker: a vector table of single-cycle steps with expected
// post-edge outputs, plus a generated fill/drain sequence across pointer wraps.
module tb_trace_checker;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] END_PC = 32'h1c000100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] debugWbPc, debugWbRfWdata, goldPc, goldWdata;
  logic [3:0]  debugWbRfWe;
  logic [4:0]  debugWbRfWnum, goldWnum;
  logic        goldValid, goldReady, passOut, errOut;
  logic [2:0]  errCode;
  logic [31:0] errPc, errExpWdata, errGotWdata, retireCnt;

  always #5 clk = ~clk;

  trace_checker #(.DEPTH(DEPTH), .END_PC(END_PC)) dut (
    .clk(clk), .reset(reset),
    .debug_wb_pc(debugWbPc), .debug_wb_rf_we(debugWbRfWe),
    .debug_wb_rf_wnum(debugWbRfWnum), .debug_wb_rf_wdata(debugWbRfWdata),
    .gold_valid(goldValid), .gold_ready(goldReady),
    .gold_pc(goldPc), .gold_wnum(goldWnum), .gold_wdata(goldWdata),
    .pass(passOut), .err(errOut), .err_code(errCode), .err_pc(errPc),
    .err_exp_wdata(errExpWdata), .err_got_wdata(errGotWdata),
    .retire_cnt(retireCnt)
  );

  typedef struct {
    logic        rst;
    logic        gv;
    logic [31:0] gpc;
    logic [4:0]  gwn;
    logic [31:0] gwd;
    logic [3:0]  we;
    logic [4:0]  wn;
    logic [31:0] pc;
    logic [31:0] wd;
    logic        xReady;
    logic        xPass;
    logic        xErr;
    logic [2:0]  xCode;
    logic [31:0] xRetire;
    logic [31:0] xEpc;
    logic [31:0] xEexp;
    logic [31:0] xEgot;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rec_t;

  vec_t tbl[$];
  vec_t expQ[$];
  int   tagQ[$];
  rec_t goldQ[$];
  int   nCompared = 0;
  int   nMismatched = 0;

  function automatic vec_t mk(
    input logic rst, input logic gv, input logic [31:0] gpc, input logic [4:0] gwn,
    input logic [31:0] gwd, input logic [3:0] we, input logic [4:0] wn,
    input logic [31:0] pc, input logic [31:0] wd,
    input logic xr, input logic xp, input logic xe, input logic [2:0] xc,
    input logic [31:0] xrt, input logic [31:0] xepc, input logic [31:0] xeexp,
    input logic [31:0] xegot);
    vec_t v;
    v.rst = rst; v.gv = gv; v.gpc = gpc; v.gwn = gwn; v.gwd = gwd;
    v.we = we; v.wn = wn; v.pc = pc; v.wd = wd;
    v.xReady = xr; v.xPass = xp; v.xErr = xe; v.xCode = xc; v.xRetire = xrt;
    v.xEpc = xepc; v.xEexp = xeexp; v.xEgot = xegot;
    return v;
  endfunction

  task automatic cmp(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int tag);
    @(negedge clk);
    reset          = v.rst;
    goldValid      = v.gv;
    goldPc         = v.gpc;
    goldWnum       = v.gwn;
    goldWdata      = v.gwd;
    debugWbRfWe    = v.we;
    debugWbRfWnum  = v.wn;
    debugWbPc      = v.pc;
    debugWbRfWdata = v.wd;
    expQ.push_back(v);
    tagQ.push_back(tag);
  endtask

  task automatic checkOutput();
    vec_t e;
    int   tag;
    @(posedge clk);
    #1;
    e   = expQ.pop_front();
    tag = tagQ.pop_front();
    cmp("gold_ready",    tag, {31'd0, goldReady}, {31'd0, e.xReady});
    cmp("pass",          tag, {31'd0, passOut},   {31'd0, e.xPass});
    cmp("err",           tag, {31'd0, errOut},    {31'd0, e.xErr});
    cmp("err_code",      tag, {29'd0, errCode},   {29'd0, e.xCode});
    cmp("retire_cnt",    tag, retireCnt,          e.xRetire);
    cmp("err_pc",        tag, errPc,              e.xEpc);
    cmp("err_exp_wdata", tag, errExpWdata,        e.xEexp);
    cmp("err_got_wdata", tag, errGotWdata,        e.xEgot);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    rec_t r;
    rec_t h;
    int   retire;
    int   nextId;

    reset = 1'b1; goldValid = 1'b0; goldPc = '0; goldWnum = '0; goldWdata = '0;
    debugWbRfWe = '0; debugWbRfWnum = '0; debugWbPc = '0; debugWbRfWdata = '0;

    // reset, then three matching commits and END_PC
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h1c000000,1,32'h5, 0,0,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h1c000004,2,32'h7, 0,0,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h1c000008,3,32'hc, 0,0,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'hf,1,32'h1c000000,32'h5, 1,0,0,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'hf,2,32'h1c000004,32'h7, 1,0,0,0,2,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'hf,3,32'h1c000008,32'hc, 1,0,0,0,3,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'h0,0,END_PC,0,           0,1,0,0,3,0,0,0));
    tbl.push_back(mk(0,1,32'h1,1,32'h1, 4'hf,5,0,32'h55,   0,1,0,0,3,0,0,0));
    // data mismatch, frozen FAIL, one-cycle reset, underflow with gold_valid high
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h1c000000,1,32'h5, 0,0,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h1c000004,2,32'h7, 0,0,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'hf,1,32'h1c000000,32'h5, 1,0,0,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'hf,2,32'h1c000004,32'h6, 0,0,1,3,2,32'h1c000004,32'h7,32'h6));
    tbl.push_back(mk(0,1,32'h1c00000c,4,32'h9, 4'hf,4,32'h1c00000c,32'h9, 0,0,1,3,2,32'h1c000004,32'h7,32'h6));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h1c000010,4,32'h11223344, 0,0,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'hf,4,32'h1c000010,32'h11223344, 1,0,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,32'h1c000014,5,32'hdeadbeef, 4'hf,5,32'h1c000014,32'hdeadbeef, 0,0,1,4,2,32'h1c000014,32'h0,32'hdeadbeef));
    // r0 writes and we=0 never pop; a low-byte-only write ignores upper bytes
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h1c000020,5,32'h000000aa, 0,0,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'hf,0,32'h1c000020,32'h12345678, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'h0,5,32'h1c000020,32'h0,        1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'h1,5,32'h1c000020,32'hffffffaa, 1,0,0,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'hf,6,32'h1c000024,32'h1, 0,0,1,4,2,32'h1c000024,32'h0,32'h1));
    // pc mismatch outranks wnum/data; wnum mismatch outranks data
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h1c000030,6,32'h1, 0,0,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'hf,7,32'h1c000034,32'h2, 0,0,1,1,1,32'h1c000034,32'h1,32'h2));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h1c000030,6,32'h1, 0,0,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'hf,7,32'h1c000030,32'h2, 0,0,1,2,1,32'h1c000030,32'h1,32'h2));
    // error on the END_PC commit: FAIL wins over PASS
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,END_PC,1,32'h1, 0,0,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'hf,1,END_PC,32'h2, 0,0,1,3,1,END_PC,32'h1,32'h2));
    // single enabled byte that differs is caught
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h1c000040,8,32'h0000ab00, 0,0,0,0, 1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 4'h2,8,32'h1c000040,32'h0000ac00, 0,0,1,3,1,32'h1c000040,32'h0000ab00,32'h0000ac00));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));

    $display("[TB] running %0d table steps", tbl.size());
    foreach (tbl[i]) begin
      applyStimulus(tbl[i], i);
      checkOutput();
    end

    // fill past full, pop one, push+pop together, drain; four rounds wrap pointers
    retire = 0;
    nextId = 0;
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int i = 0; i <= DEPTH; i++) begin
        r.pc    = 32'h1c001000 + 32'(nextId) * 4;
        r.wnum  = 5'(nextId % 31 + 1);
        r.wdata = $urandom;
        nextId++;
        if (i < DEPTH) goldQ.push_back(r);
        v = mk(0,1,r.pc,r.wnum,r.wdata, 0,0,0,0,
               (i + 1 < DEPTH),0,0,0,32'(retire),0,0,0);
        applyStimulus(v, 1000 + rnd * 100 + i);
        checkOutput();
      end
      h = goldQ.pop_front();
      retire++;
      v = mk(0,0,0,0,0, 4'hf,h.wnum,h.pc,h.wdata, 1,0,0,0,32'(retire),0,0,0);
      applyStimulus(v, 1000 + rnd * 100 + 50);
      checkOutput();
      r.pc    = 32'h1c001000 + 32'(nextId) * 4;
      r.wnum  = 5'(nextId % 31 + 1);
      r.wdata = $urandom;
      nextId++;
      h = goldQ.pop_front();
      goldQ.push_back(r);
      retire++;
      v = mk(0,1,r.pc,r.wnum,r.wdata, 4'hf,h.wnum,h.pc,h.wdata,
             1,0,0,0,32'(retire),0,0,0);
      applyStimulus(v, 1000 + rnd * 100 + 51);
      checkOutput();
      for (int j = 0; j < DEPTH - 1; j++) begin
        h = goldQ.pop_front();
        retire++;
        v = mk(0,0,0,0,0, 4'hf,h.wnum,h.pc,h.wdata, 1,0,0,0,32'(retire),0,0,0);
        applyStimulus(v, 1000 + rnd * 100 + 60 + j);
        checkOutput();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/trace_checker.md
# trace_checker

Golden-trace comparator on the other end of the CPU trace debug interface (debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata).
- A loader streams expected register-write records into an internal FIFO over a valid/ready handshake.
- Each architectural register write the CPU commits is popped against the FIFO head and compared.
- The block reports pass/fail, the first mismatch, and a retired-write count.
- It sits in the SoC test bench wrapper beside mycpu_top.

## Interface
Parameters:
- DEPTH, 8: golden FIFO entries; power of two, ≥2
- END_PC, 32'h1c000100: PC value that ends the test

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- debug_wb_pc  in  32  CPU PC of the current write-back
- debug_wb_rf_we  in  4  per-byte register-file write enable
- debug_wb_rf_wnum  in  5  destination register
- debug_wb_rf_wdata  in  32  write data
- gold_valid  in  1  golden record offered
- gold_ready  out  1  FIFO accepts record
- gold_pc  in  32  expected PC
- gold_wnum  in  5  expected destination
- gold_wdata  in  32  expected data
- pass  out  1  END_PC reached with no error
- err  out  1  mismatch or underflow detected
- err_code  out  3  0 none, 1 pc, 2 wnum, 3 wdata, 4 underflow
- err_pc  out  32  debug_wb_pc of the failing commit
- err_exp_wdata  out  32  expected wdata at failure (0 on underflow)
- err_got_wdata  out  32  observed wdata at failure
- retire_cnt  out  32  count of checked commits

## Operation
Commit event: rf_we != 4'b0000 and rf_wnum != 0. Writes to r0 are never checked and never pop.

FIFO:
- Push on gold_valid && gold_ready.
- gold_ready = (count < DEPTH) && state == RUN. This is computed from the registered count: a full FIFO refuses even on a cycle that also pops.
- Pop on every commit while in RUN with count > 0.
- Read and write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

Compare, against the FIFO head, in this priority order:
- pc != gold_pc → code 1
- wnum != gold_wnum → code 2
- masked data mismatch → code 3. Byte i is compared only where rf_we[i]=1.
- A commit with count == 0 → code 4, underflow. There is no bypass: a push in the same cycle does not satisfy the commit.

State machine:
- RUN is entered on reset.
- RUN → FAIL on any compare error. Latch err_code, err_pc, err_exp_wdata, err_got_wdata.
- RUN → PASS when debug_wb_pc == END_PC and the same cycle has no error. If that cycle has an error, FAIL wins.
- PASS and FAIL are terminal until reset. In both: commits are ignored, there are no pops, gold_ready=0, and retire_cnt is frozen.

Counters and flags:
- retire_cnt increments on every commit checked in RUN, including the failing one. It wraps at 2^32.
- pass = (state == PASS); err = (state == FAIL). They are mutually exclusive.

## Timing
Reset values:
- All outputs 0; state RUN; FIFO empty.
- gold_ready rises in the first cycle after reset deasserts.

Latency:
- Compare is combinational on the commit cycle.
- err, err_* and pass are registered: visible one cycle after the offending or ending cycle.
- retire_cnt updates one cycle after each commit.
- A pushed record is poppable from the next cycle.

Reset mid-operation: state returns to RUN, the FIFO is flushed, and all latched error fields and retire_cnt clear on the next edge.

Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.

## Test plan
- Push 3 records {1c000000,r1,5}, {1c000004,r2,7}, {1c000008,r3,c}. Drive matching commits, then pc=END_PC → retire_cnt=3, pass=1 one cycle later, err=0.
- Commit with wdata=6 where 7 is expected at pc 1c000004 → err=1, err_code=3, err_pc=1c000004, err_exp_wdata=7, err_got_wdata=6. gold_ready=0 afterwards.
- Commit with an empty FIFO, with gold_valid high in the same cycle → err_code=4, err_exp_wdata=0.
- Hold gold_valid for DEPTH+1 records with no commits → exactly DEPTH accepted and gold_ready=0. After one commit pops, gold_ready=1 again. Repeat across ≥3 pointer wraps with no false errors.
- Commit with rf_wnum=0 and arbitrary data, plus a commit with we=0 → no pop, retire_cnt unchanged. A we=4'b0001 commit with an upper-byte difference only → no error.
- Assert reset for 1 cycle while in FAIL → err=0, err_code=0, retire_cnt=0, FIFO empty, then normal checking resumes.
